// File: rtl/beacon_pkg.sv
// ---------------------------------------------------------------------------
// beacon_pkg
// Shared definitions for the multi-channel beacon waveform generator:
//   - state_e     : run-control FSM states (IDLE, RUN, DRAIN)
//   - DEF_DATA_W  : default signed sample width
//   - DEF_AMP_W   : default gain width (unsigned Q1.(AMP_W-1))
//   - sat_shift() : arithmetic right shift followed by saturation to a
//                   signed range of a given width
// ---------------------------------------------------------------------------
package beacon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_AMP_W  = 8;

    // Width of the working value inside sat_shift; callers must keep their
    // full product (DATA_W + AMP_W + 1 bits) at or below this.
    localparam int SAT_WORK_W = 64;

    // Shifts a signed product right arithmetically (floor rounding) and
    // clamps it to [-2^(width-1), 2^(width-1)-1]. The result is returned at
    // full working width; the caller keeps the low 'width' bits.
    function automatic logic signed [SAT_WORK_W-1:0] sat_shift(
        input logic signed [SAT_WORK_W-1:0] product,
        input int                           shift,
        input int                           width
    );
        logic signed [SAT_WORK_W-1:0] shifted;
        logic signed [SAT_WORK_W-1:0] maxVal;
        logic signed [SAT_WORK_W-1:0] minVal;
        shifted = product >>> shift;
        maxVal  = (64'sd1 <<< (width - 1)) - 64'sd1;
        minVal  = -maxVal - 64'sd1;
        if (shifted > maxVal) begin
            sat_shift = maxVal;
        end else if (shifted < minVal) begin
            sat_shift = minVal;
        end else begin
            sat_shift = shifted;
        end
    endfunction

endpackage

// File: rtl/beacon_scale_sat.sv
// ---------------------------------------------------------------------------
// beacon_scale_sat
// Output stage of one beacon channel: multiplies a signed table sample by an
// unsigned Q1.(AMP_W-1) gain, shifts back to sample scale, saturates and
// registers the result. A cleared valid or a flush forces the output to 0.
//
// Ports:
//   Clk       in   clock, rising edge
//   Rst_n     in   synchronous active-low reset
//   flush_i   in   clears the output register at the next edge
//   valid_i   in   sample_i is a live sample (otherwise output 0)
//   sample_i  in   signed DATA_W table sample
//   gain_i    in   unsigned AMP_W gain, 2^(AMP_W-1) is unity
//   data_o    out  registered, scaled, saturated signed sample
// ---------------------------------------------------------------------------
module beacon_scale_sat
    import beacon_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMP_W  = DEF_AMP_W
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic        [AMP_W-1:0]  gain_i,
    output logic signed [DATA_W-1:0] data_o
);

    localparam int PROD_W = DATA_W + AMP_W + 1;

    logic signed [PROD_W-1:0]     product;
    logic signed [SAT_WORK_W-1:0] productExt;
    logic signed [DATA_W-1:0]     data_d;
    logic signed [DATA_W-1:0]     data_q;

    // The gain gets a zero sign bit so that the full unsigned range (up to
    // just under 2x) multiplies as a positive value.
    always_comb begin
        product    = PROD_W'(sample_i) * PROD_W'($signed({1'b0, gain_i}));
        productExt = SAT_WORK_W'(product);
        data_d     = '0;
        if (valid_i) begin
            data_d = DATA_W'(sat_shift(productExt, AMP_W - 1, DATA_W));
        end
    end

    // Output register; idle slots are held at 0 rather than the last sample.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            data_q <= '0;
        end else if (flush_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/beacon_wave_gen.sv
// ---------------------------------------------------------------------------
// beacon_wave_gen
// Multi-channel beacon waveform generator. One writable sample table of
// DEPTH entries is played by NUM_CH channels, each starting at its own phase
// offset. Samples are gain-scaled with saturation. Runs either continuously
// or as a counted burst of whole table periods with a busy/done handshake.
// Latency from a registered index to its output sample is 2 clocks.
//
// Ports:
//   Clk             in   clock, rising edge
//   Rst_n           in   synchronous active-low reset (table not cleared)
//   enable          in   block enable; low forces IDLE and flushes outputs
//   mode            in   0 = continuous, 1 = burst (latched at run start)
//   start           in   burst start pulse
//   burst_periods   in   table periods per burst, 0 acts as 1 (latched)
//   gain            in   unsigned Q1.(AMP_W-1) gain (latched)
//   phase_ofs       in   per-channel start offsets, ch c at [c*ADDR_W +: ADDR_W]
//   tbl_we          in   table write strobe
//   tbl_addr        in   table write address (>= DEPTH ignored)
//   tbl_wdata       in   signed table write data
//   BeaconData_out  out  signed samples, ch c at [c*DATA_W +: DATA_W]
//   out_valid       out  BeaconData_out holds live samples
//   busy            out  FSM not IDLE
//   done            out  one-cycle pulse at the end of a burst
// ---------------------------------------------------------------------------
module beacon_wave_gen
    import beacon_pkg::*;
#(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    DEPTH     = 40,
    parameter int    ADDR_W    = 6,
    parameter int    NUM_CH    = 2,
    parameter int    AMP_W     = DEF_AMP_W,
    parameter int    CNT_W     = 16,
    parameter string INIT_FILE = ""
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       enable,
    input  logic                       mode,
    input  logic                       start,
    input  logic [CNT_W-1:0]           burst_periods,
    input  logic [AMP_W-1:0]           gain,
    input  logic [NUM_CH*ADDR_W-1:0]   phase_ofs,
    input  logic                       tbl_we,
    input  logic [ADDR_W-1:0]          tbl_addr,
    input  logic [DATA_W-1:0]          tbl_wdata,
    output logic [NUM_CH*DATA_W-1:0]   BeaconData_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]          periodCnt_q, periodCnt_d;
    logic                      drainCnt_q, drainCnt_d;
    logic                      done_q, done_d;
    logic                      mode_q, mode_d;
    logic [AMP_W-1:0]          gain_q, gain_d;
    logic [NUM_CH*ADDR_W-1:0]  ofs_q, ofs_d;
    logic [CNT_W-1:0]          periods_q, periods_d;
    logic                      rdValid_q;
    logic                      outValid_q;

    logic signed [DATA_W-1:0]  tblMem [0:DEPTH-1];
    logic [ADDR_W-1:0]         rdAddr [NUM_CH];
    logic signed [DATA_W-1:0]  rdData_q [NUM_CH];
    logic [ADDR_W-1:0]         ofsEff;
    logic [ADDR_W:0]           addrSum;

    // Run-control FSM. Run parameters are captured only on the IDLE->RUN
    // transition so mid-run input changes cannot disturb a waveform. A low
    // enable overrides every state and returns to IDLE without a done pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        periodCnt_d = periodCnt_q;
        drainCnt_d  = drainCnt_q;
        done_d      = 1'b0;
        mode_d      = mode_q;
        gain_d      = gain_q;
        ofs_d       = ofs_q;
        periods_d   = periods_q;

        case (state_q)
            IDLE: begin
                idx_d       = '0;
                periodCnt_d = '0;
                drainCnt_d  = 1'b0;
                if (enable && (!mode || start)) begin
                    state_d   = RUN;
                    mode_d    = mode;
                    gain_d    = gain;
                    ofs_d     = phase_ofs;
                    periods_d = (burst_periods == '0) ? CNT_W'(1) : burst_periods;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    periodCnt_d = periodCnt_q + CNT_W'(1);
                    if (mode_q && ((periodCnt_q + CNT_W'(1)) == periods_q)) begin
                        state_d    = DRAIN;
                        drainCnt_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Two cycles let the last index pass both pipeline stages
                // before done is raised.
                if (drainCnt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drainCnt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d     = IDLE;
            idx_d       = '0;
            periodCnt_d = '0;
            drainCnt_d  = 1'b0;
            done_d      = 1'b0;
        end
    end

    // Control registers plus the valid tags that travel alongside the two
    // data pipeline stages. Dropping enable clears both tags immediately.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            periodCnt_q <= '0;
            drainCnt_q  <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
            gain_q      <= '0;
            ofs_q       <= '0;
            periods_q   <= '0;
            rdValid_q   <= 1'b0;
            outValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            periodCnt_q <= periodCnt_d;
            drainCnt_q  <= drainCnt_d;
            done_q      <= done_d;
            mode_q      <= mode_d;
            gain_q      <= gain_d;
            ofs_q       <= ofs_d;
            periods_q   <= periods_d;
            rdValid_q   <= enable && (state_q == RUN);
            outValid_q  <= enable && rdValid_q;
        end
    end

    // Table write port. Out-of-range addresses are dropped. Contents survive
    // reset on purpose so a table loaded once stays valid.
    always_ff @(posedge Clk) begin
        if (tbl_we && (int'(tbl_addr) < DEPTH)) begin
            tblMem[tbl_addr] <= tbl_wdata;
        end
    end

    // Per-channel read address: (idx + offset) mod DEPTH using a single
    // conditional subtract, valid because both terms are below DEPTH.
    // Offsets outside the table fall back to 0.
    always_comb begin
        ofsEff  = '0;
        addrSum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ofsEff = ofs_q[c*ADDR_W +: ADDR_W];
            if (int'(ofsEff) >= DEPTH) begin
                ofsEff = '0;
            end
            addrSum = {1'b0, idx_q} + {1'b0, ofsEff};
            if (addrSum >= DEPTH_EXT) begin
                rdAddr[c] = ADDR_W'(addrSum - DEPTH_EXT);
            end else begin
                rdAddr[c] = addrSum[ADDR_W-1:0];
            end
        end
    end

    // Stage 1: registered table read. A write to the same address at the
    // same edge is not visible until the following read.
    always_ff @(posedge Clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            rdData_q[c] <= tblMem[rdAddr[c]];
        end
    end

    // Stage 2: one scale/saturate register per channel.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            beacon_scale_sat #(
                .DATA_W (DATA_W),
                .AMP_W  (AMP_W)
            ) u_scale (
                .Clk      (Clk),
                .Rst_n    (Rst_n),
                .flush_i  (!enable),
                .valid_i  (rdValid_q),
                .sample_i (rdData_q[c]),
                .gain_i   (gain_q),
                .data_o   (BeaconData_out[c*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign out_valid = outValid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
